// File: rtl/transport_send_if.sv
// Upper-layer command bus and byte-serial packet output of the transport framer.
interface transport_send_if;
  logic [1:0]  cmd;
  logic [15:0] data;
  logic        sendData;
  logic        sending;
  logic [7:0]  packetOut;
  logic        busy;
  logic        ready_data_count;

  modport master (
    output cmd, data, sendData,
    input  sending, packetOut, busy, ready_data_count
  );

  modport slave (
    input  cmd, data, sendData,
    output sending, packetOut, busy, ready_data_count
  );
endinterface

// File: rtl/transport_send.sv
// Transport transmit framer: buffers 16-bit words and emits header + MSB/LSB payload bytes.
// Control packets take priority over data; outputs are registered, header appears one cycle after the start decision.
module transport_send #(
  parameter int FIFO_DEPTH   = 16,
  parameter int PACKET_WORDS = 8
) (
  input  logic            clk,
  input  logic            reset,
  transport_send_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PKT_CNT  = (AW+1)'(PACKET_WORDS);

  typedef enum logic [1:0] {IDLE, HEADER, MSB, LSB} state_t;

  state_t        state;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          pending;
  logic [15:0]   ctrl_word;
  logic [15:0]   tx_word;
  logic          is_ctrl;
  logic [3:0]    words_left;
  logic          sending;
  logic [7:0]    packet_byte;
  logic          busy;
  logic          ready;

  logic          wr_en;
  logic          rd_en;
  logic          flush;
  logic          start_ctrl;
  logic          start_data;
  logic          emit_msb;
  logic [3:0]    data_len;

  always_comb begin
    flush      = (bus.cmd == 2'b11) && (state == IDLE);
    wr_en      = (bus.cmd == 2'b01) && (count != FULL_CNT);
    start_ctrl = (state == IDLE) && pending;
    // A flush in the same cycle wins over starting a data packet from the words it discards.
    start_data = (state == IDLE) && !pending && bus.sendData && (count != '0) && !flush;
    emit_msb   = (state == HEADER) || ((state == LSB) && (words_left != 4'd0));
    rd_en      = emit_msb && !is_ctrl;
    data_len   = (count >= PKT_CNT) ? 4'(PACKET_WORDS) : 4'(count);
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sending     <= 1'b0;
      packet_byte <= 8'h00;
      busy        <= 1'b0;
      ready       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      pending     <= 1'b0;
      ctrl_word   <= 16'h0000;
      tx_word     <= 16'h0000;
      is_ctrl     <= 1'b0;
      words_left  <= 4'd0;
    end else begin
      count <= count_next;
      ready <= (count_next >= PKT_CNT);

      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      // A new control request landing on the service cycle stays pending for the next packet.
      if (bus.cmd == 2'b10) begin
        pending   <= 1'b1;
        ctrl_word <= bus.data;
      end else if (start_ctrl) begin
        pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_ctrl) begin
            state       <= HEADER;
            is_ctrl     <= 1'b1;
            words_left  <= 4'd1;
            tx_word     <= ctrl_word;
            sending     <= 1'b1;
            busy        <= 1'b1;
            packet_byte <= {2'b10, 2'b00, 4'd1};
          end else if (start_data) begin
            state       <= HEADER;
            is_ctrl     <= 1'b0;
            words_left  <= data_len;
            sending     <= 1'b1;
            busy        <= 1'b1;
            packet_byte <= {2'b01, 2'b00, data_len};
          end
        end
        HEADER, LSB: begin
          if (emit_msb) begin
            state      <= MSB;
            words_left <= words_left - 4'd1;
            if (is_ctrl) begin
              packet_byte <= tx_word[15:8];
            end else begin
              packet_byte <= mem[rd_ptr][15:8];
              tx_word     <= mem[rd_ptr];
            end
          end else begin
            state       <= IDLE;
            sending     <= 1'b0;
            busy        <= 1'b0;
            packet_byte <= 8'h00;
          end
        end
        MSB: begin
          state       <= LSB;
          packet_byte <= tx_word[7:0];
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sending          = sending;
  assign bus.packetOut        = packet_byte;
  assign bus.busy             = busy;
  assign bus.ready_data_count = ready;
endmodule

// File: tb/tb_transport_send.sv
// Directed and randomized checks of transport_send against a packet-level reference model.
module tb_transport_send;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  transport_send_if bus();

  transport_send #(.FIFO_DEPTH(16), .PACKET_WORDS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         pop;
  } ent_t;

  logic [15:0] q[$];
  ent_t        pkt[$];
  bit          m_pending;
  logic [15:0] m_ctrl;
  logic        e_send;
  logic [7:0]  e_out;
  logic        e_busy;
  logic        e_rdy;

  function automatic ent_t mk(input logic [7:0] b, input bit pop);
    ent_t e;
    e.b   = b;
    e.pop = pop;
    return e;
  endfunction

  // Reference: a packet is the list of bytes it will emit; FIFO words leave when their MSB byte goes out.
  task automatic model(input logic [1:0] c, input logic [15:0] d, input logic s);
    bit   idle;
    bit   pop;
    bit   full;
    ent_t e;
    int   len;
    if (reset) begin
      q.delete();
      pkt.delete();
      m_pending = 0;
      m_ctrl    = 16'h0;
      e_send    = 1'b0;
      e_out     = 8'h00;
      e_busy    = 1'b0;
      e_rdy     = 1'b0;
      return;
    end
    idle = !e_send;
    pop  = 0;
    full = (q.size() == 16);
    if (pkt.size() > 0) begin
      e      = pkt.pop_front();
      e_send = 1'b1;
      e_out  = e.b;
      pop    = e.pop;
    end else if (idle && m_pending) begin
      pkt.push_back(mk(m_ctrl[15:8], 0));
      pkt.push_back(mk(m_ctrl[7:0], 0));
      e_send    = 1'b1;
      e_out     = 8'h81;
      m_pending = 0;
    end else if (idle && s && q.size() > 0 && c != 2'b11) begin
      len    = (q.size() < 8) ? q.size() : 8;
      e_send = 1'b1;
      e_out  = 8'(32'h40 + len);
      for (int i = 0; i < len; i++) begin
        pkt.push_back(mk(q[i][15:8], 1));
        pkt.push_back(mk(q[i][7:0], 0));
      end
    end else begin
      e_send = 1'b0;
      e_out  = 8'h00;
    end
    e_busy = e_send;
    if (pop) void'(q.pop_front());
    if (c == 2'b01 && !full) q.push_back(d);
    if (c == 2'b11 && idle) q.delete();
    if (c == 2'b10) begin
      m_pending = 1;
      m_ctrl    = d;
    end
    e_rdy = (q.size() >= 8);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] c, input logic [15:0] d, input logic s);
    bus.cmd      = c;
    bus.data     = d;
    bus.sendData = s;
    @(posedge clk);
    model(c, d, s);
    #1;
    chk("sending",   {7'd0, bus.sending},          {7'd0, e_send});
    chk("packetOut", bus.packetOut,                e_out);
    chk("busy",      {7'd0, bus.busy},             {7'd0, e_busy});
    chk("ready",     {7'd0, bus.ready_data_count}, {7'd0, e_rdy});
  endtask

  task automatic idle_n(input int n, input logic s);
    for (int i = 0; i < n; i++) step(2'b00, 16'h0, s);
  endtask

  initial begin
    reset        = 1'b1;
    bus.cmd      = 2'b00;
    bus.data     = 16'h0;
    bus.sendData = 1'b0;
    idle_n(2, 0);
    reset = 1'b0;

    // three words, one short data packet
    for (int i = 0; i < 3; i++) step(2'b01, 16'h0044, 0);
    step(2'b00, 16'h0, 0);
    step(2'b00, 16'h0, 1);
    idle_n(10, 0);

    // saturate the FIFO, then two back-to-back full packets
    for (int i = 0; i < 20; i++) step(2'b01, 16'h0044, 0);
    idle_n(2, 0);
    idle_n(40, 1);
    idle_n(3, 0);

    // control packet while idle
    step(2'b10, 16'hBEEF, 0);
    idle_n(5, 0);

    // control request during a data packet jumps ahead of the next data packet
    for (int i = 0; i < 12; i++) step(2'b01, 16'(32'h0101 * (i + 1)), 0);
    idle_n(3, 1);
    step(2'b10, 16'h1234, 1);
    idle_n(40, 1);

    // reset in the middle of a payload
    for (int i = 0; i < 5; i++) step(2'b01, 16'hA000 + 16'(i), 0);
    idle_n(4, 1);
    reset = 1'b1;
    step(2'b00, 16'h0, 1);
    reset = 1'b0;
    idle_n(6, 1);

    // flush while idle discards queued words
    step(2'b01, 16'h1111, 0);
    step(2'b01, 16'h2222, 0);
    step(2'b11, 16'h0, 0);
    idle_n(5, 1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      int          r;
      logic [1:0]  c;
      r = int'($urandom_range(0, 19));
      if (r < 8)       c = 2'b00;
      else if (r < 16) c = 2'b01;
      else if (r < 18) c = 2'b10;
      else             c = 2'b11;
      reset = ($urandom_range(0, 299) == 0);
      step(c, 16'($urandom), logic'($urandom_range(0, 2) != 0));
    end
    reset = 1'b0;
    idle_n(40, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
